led_fader: RTL and testbench

//  Downstream stage of the LED blinker: consumes its per-LED on/off levels and drives the

---
 rtl/led_fader.sv | 112 +++++++++++
 tb/tb_led_fader.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/led_fader.sv
// PWM LED fader: ramps per-channel brightness toward the requested on/off level.
// Build option: define LED_FADER_INVERT_EN for active-low LED pins.
module led_fader #(
    parameter int NUM_LED  = 2,
    parameter int PWM_BITS = 8,
    parameter int STEP_DIV = 94_118
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_LED-1:0]           led_req,
    output logic [NUM_LED-1:0]           led_pwm,
    output logic [NUM_LED*PWM_BITS-1:0]  level,
    output logic [NUM_LED-1:0]           busy
);

    localparam int SW = $clog2(STEP_DIV);
    localparam logic [PWM_BITS-1:0] MAX = '1;
    localparam logic [SW-1:0] STEP_LAST = SW'(STEP_DIV - 1);
`ifdef LED_FADER_INVERT_EN
    localparam logic PWM_INV = 1'b1;
`else
    localparam logic PWM_INV = 1'b0;
`endif

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        RISE = 2'd1,
        ON   = 2'd2,
        FALL = 2'd3
    } state_t;

    logic [PWM_BITS-1:0] pwm_cnt_q;
    logic [SW-1:0]       step_q;
    logic                step_tick;

    state_t              state_q [NUM_LED];
    state_t              state_d [NUM_LED];
    logic [PWM_BITS-1:0] lvl_q   [NUM_LED];
    logic [PWM_BITS-1:0] lvl_d   [NUM_LED];
    logic [NUM_LED-1:0]  busy_q;
    logic [NUM_LED-1:0]  pwm_q;

    assign step_tick = (step_q == STEP_LAST);

    // Level moves with the current state; a request change beats ramp completion.
    always_comb begin
        for (int i = 0; i < NUM_LED; i++) begin
            lvl_d[i]   = lvl_q[i];
            state_d[i] = state_q[i];
            if (step_tick && state_q[i] == RISE && lvl_q[i] != MAX)
                lvl_d[i] = lvl_q[i] + 1'b1;
            if (step_tick && state_q[i] == FALL && lvl_q[i] != '0)
                lvl_d[i] = lvl_q[i] - 1'b1;
            unique case (state_q[i])
                OFF: begin
                    if (led_req[i])
                        state_d[i] = RISE;
                end
                RISE: begin
                    if (!led_req[i])
                        state_d[i] = FALL;
                    else if (lvl_d[i] == MAX)
                        state_d[i] = ON;
                end
                ON: begin
                    if (!led_req[i])
                        state_d[i] = FALL;
                end
                FALL: begin
                    if (led_req[i])
                        state_d[i] = RISE;
                    else if (lvl_d[i] == '0)
                        state_d[i] = OFF;
                end
                default: state_d[i] = OFF;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pwm_cnt_q <= '0;
            step_q    <= '0;
            busy_q    <= '0;
            pwm_q     <= {NUM_LED{PWM_INV}};
            for (int i = 0; i < NUM_LED; i++) begin
                state_q[i] <= OFF;
                lvl_q[i]   <= '0;
            end
        end else begin
            pwm_cnt_q <= pwm_cnt_q + 1'b1;
            step_q    <= step_tick ? '0 : step_q + SW'(1);
            for (int i = 0; i < NUM_LED; i++) begin
                state_q[i] <= state_d[i];
                lvl_q[i]   <= lvl_d[i];
                busy_q[i]  <= (state_d[i] == RISE) || (state_d[i] == FALL);
                // Full scale is forced to 100% duty instead of MAX/2**PWM_BITS.
                pwm_q[i]   <= PWM_INV ^ ((lvl_q[i] == MAX) || (pwm_cnt_q < lvl_q[i]));
            end
        end
    end

    always_comb begin
        level = '0;
        for (int i = 0; i < NUM_LED; i++)
            level[i*PWM_BITS +: PWM_BITS] = lvl_q[i];
    end

    assign led_pwm = pwm_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_led_fader.sv
// Bench for led_fader: directed vector table, duty check, random run vs model.
// Honours LED_FADER_INVERT_EN for the expected pin polarity.
module tb_led_fader;

    localparam int NL   = 2;
    localparam int PB   = 3;
    localparam int SDIV = 4;
    localparam int MAXV = 7;
`ifdef LED_FADER_INVERT_EN
    localparam logic INV = 1'b1;
`else
    localparam logic INV = 1'b0;
`endif
    localparam logic [1:0] RST_PWM = {2{INV}};

    logic          clk = 1'b0;
    logic          rst_r;
    logic [1:0]    led_req;
    logic [1:0]    led_pwm;
    logic [5:0]    level;
    logic [1:0]    busy;

    logic          rst_s;
    logic [1:0]    req_s;
    logic [1:0]    pwm_s;
    logic [5:0]    lvl_s;
    logic [1:0]    busy_s;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    led_fader #(.NUM_LED(NL), .PWM_BITS(PB), .STEP_DIV(SDIV)) u_dut (
        .clk     (clk),
        .reset   (rst_r),
        .led_req (led_req),
        .led_pwm (led_pwm),
        .level   (level),
        .busy    (busy)
    );

    led_fader #(.NUM_LED(NL), .PWM_BITS(PB), .STEP_DIV(1000)) u_slow (
        .clk     (clk),
        .reset   (rst_s),
        .led_req (req_s),
        .led_pwm (pwm_s),
        .level   (lvl_s),
        .busy    (busy_s)
    );

    // Reference: each channel has a direction (up) and a moving flag.
    int         m_lvl [2];
    bit         m_up  [2];
    bit         m_mov [2];
    int         m_k;
    int         m_p;
    logic [1:0] m_pwm;

    task automatic model_edge(input bit rst, input logic [1:0] req);
        if (rst) begin
            m_k = 0;
            m_p = 0;
            m_pwm = RST_PWM;
            for (int c = 0; c < 2; c++) begin
                m_lvl[c] = 0;
                m_up[c]  = 0;
                m_mov[c] = 0;
            end
        end else begin
            for (int c = 0; c < 2; c++) begin
                m_pwm[c] = ((m_lvl[c] == MAXV) || (m_p < m_lvl[c])) ^ INV;
                if (m_mov[c] && m_k == SDIV - 1) begin
                    if (m_up[c]) m_lvl[c] = (m_lvl[c] < MAXV) ? m_lvl[c] + 1 : MAXV;
                    else         m_lvl[c] = (m_lvl[c] > 0) ? m_lvl[c] - 1 : 0;
                end
                if (req[c] != m_up[c]) begin
                    m_up[c]  = req[c];
                    m_mov[c] = 1;
                end else if (m_mov[c] && m_lvl[c] == (m_up[c] ? MAXV : 0)) begin
                    m_mov[c] = 0;
                end
            end
            m_k = (m_k + 1) % SDIV;
            m_p = (m_p + 1) % 8;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, a, e);
        end
    endtask

    task automatic step(input bit rst, input logic [1:0] req);
        rst_r   = rst;
        led_req = req;
        @(posedge clk);
        model_edge(rst, req);
        #1;
        chk("model_lvl0", 32'(level[2:0]), 32'(m_lvl[0]));
        chk("model_lvl1", 32'(level[5:3]), 32'(m_lvl[1]));
        chk("model_busy", 32'(busy), 32'({m_mov[1], m_mov[0]}));
        chk("model_pwm", 32'(led_pwm), 32'(m_pwm));
    endtask

    typedef struct {
        bit         rst;
        logic [1:0] req;
        int         n;
        logic [2:0] l0;
        logic [2:0] l1;
        logic [1:0] bsy;
        bit         cp;
        logic [1:0] pwm;
    } vec_t;

    vec_t tbl[$];

    initial begin
        logic [1:0] r;
        int ones;
        int ones1;
        int waited;

        rst_r   = 1'b1;
        led_req = 2'b11;
        rst_s   = 1'b1;
        req_s   = 2'b01;

        tbl.push_back('{1, 2'b11, 3,  3'd0, 3'd0, 2'b00, 1, RST_PWM});
        tbl.push_back('{0, 2'b01, 1,  3'd0, 3'd0, 2'b01, 1, RST_PWM});
        tbl.push_back('{0, 2'b01, 3,  3'd1, 3'd0, 2'b01, 0, 2'b00});
        tbl.push_back('{0, 2'b01, 24, 3'd7, 3'd0, 2'b00, 0, 2'b00});
        tbl.push_back('{0, 2'b01, 8,  3'd7, 3'd0, 2'b00, 1, 2'b01 ^ RST_PWM});
        tbl.push_back('{1, 2'b01, 1,  3'd0, 3'd0, 2'b00, 1, RST_PWM});
        tbl.push_back('{0, 2'b01, 16, 3'd4, 3'd0, 2'b01, 0, 2'b00});
        tbl.push_back('{0, 2'b00, 1,  3'd4, 3'd0, 2'b01, 0, 2'b00});
        tbl.push_back('{0, 2'b00, 3,  3'd3, 3'd0, 2'b01, 0, 2'b00});
        tbl.push_back('{0, 2'b00, 4,  3'd2, 3'd0, 2'b01, 0, 2'b00});
        tbl.push_back('{0, 2'b00, 4,  3'd1, 3'd0, 2'b01, 0, 2'b00});
        tbl.push_back('{0, 2'b00, 4,  3'd0, 3'd0, 2'b00, 1, RST_PWM});
        tbl.push_back('{1, 2'b01, 1,  3'd0, 3'd0, 2'b00, 1, RST_PWM});
        tbl.push_back('{0, 2'b01, 27, 3'd6, 3'd0, 2'b01, 0, 2'b00});
        tbl.push_back('{0, 2'b00, 1,  3'd7, 3'd0, 2'b01, 0, 2'b00});
        tbl.push_back('{0, 2'b00, 4,  3'd6, 3'd0, 2'b01, 0, 2'b00});
        tbl.push_back('{0, 2'b00, 4,  3'd5, 3'd0, 2'b01, 0, 2'b00});
        tbl.push_back('{1, 2'b00, 1,  3'd0, 3'd0, 2'b00, 1, RST_PWM});
        tbl.push_back('{0, 2'b01, 1,  3'd0, 3'd0, 2'b01, 1, RST_PWM});
        tbl.push_back('{0, 2'b01, 3,  3'd1, 3'd0, 2'b01, 0, 2'b00});
        tbl.push_back('{0, 2'b11, 8,  3'd3, 3'd2, 2'b11, 0, 2'b00});
        tbl.push_back('{0, 2'b10, 1,  3'd3, 3'd2, 2'b11, 0, 2'b00});

        foreach (tbl[v]) begin
            for (int j = 0; j < tbl[v].n; j++)
                step(tbl[v].rst, tbl[v].req);
            chk($sformatf("vec%0d_lvl0", v), 32'(level[2:0]), 32'(tbl[v].l0));
            chk($sformatf("vec%0d_lvl1", v), 32'(level[5:3]), 32'(tbl[v].l1));
            chk($sformatf("vec%0d_busy", v), 32'(busy), 32'(tbl[v].bsy));
            if (tbl[v].cp)
                chk($sformatf("vec%0d_pwm", v), 32'(led_pwm), 32'(tbl[v].pwm));
        end

        // Random request traffic, with occasional resets.
        step(1'b1, 2'b00);
        r = 2'b00;
        for (int t = 0; t < 3000; t++) begin
            if ($urandom_range(0, 15) == 0) r[0] = ~r[0];
            if ($urandom_range(0, 15) == 0) r[1] = ~r[1];
            step($urandom_range(0, 299) == 0, r);
        end

        // Duty cycle at a frozen level 3 on the slow instance.
        @(posedge clk);
        #1;
        rst_s = 1'b0;
        waited = 0;
        while (lvl_s[2:0] != 3'd3 && waited < 5000) begin
            @(posedge clk);
            #1;
            waited++;
        end
        chk("duty_reach_lvl3", 32'(lvl_s[2:0]), 32'd3);
        repeat (2) @(posedge clk);
        #1;
        ones  = 0;
        ones1 = 0;
        for (int j = 0; j < 16; j++) begin
            @(posedge clk);
            #1;
            ones  += int'(pwm_s[0] ^ INV);
            ones1 += int'(pwm_s[1] ^ INV);
        end
        chk("duty_ch0_high", 32'(ones), 32'd6);
        chk("duty_ch1_high", 32'(ones1), 32'd0);
        chk("duty_busy", 32'(busy_s), 32'b01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
